// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared combinational ALU: two valid/ready requesters,
// registered ALU drive, one settle cycle, and a held response with requester tag.
module alu_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_acc,
    input  logic [WIDTH-1:0] alu_mulh,
    input  logic [7:0]       alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_acc,
    output logic [WIDTH-1:0] rsp_mulh,
    output logic [7:0]       rsp_flag,
    output logic             busy,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t state;
    logic   last_grant;
    logic   cur_id;
    logic   gnt_id;
    logic   take;
    req_t   req_in [2];

    assign req_in[0] = '{op: req0_op, a: req0_a, b: req0_b};
    assign req_in[1] = '{op: req1_op, a: req1_a, b: req1_b};

    // Under contention the requester that did not win last time goes first.
    always_comb begin
        gnt_id = req1_valid;
        if (req0_valid && req1_valid)
            gnt_id = ~last_grant;
        take       = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = take && !gnt_id;
        req1_ready = take && gnt_id;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_s      <= 3'b000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_acc    <= '0;
            rsp_mulh   <= '0;
            rsp_flag   <= '0;
            op_count   <= '0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        alu_s      <= req_in[gnt_id].op;
                        alu_a      <= req_in[gnt_id].a;
                        alu_b      <= req_in[gnt_id].b;
                        cur_id     <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= EXEC;
                    end else begin
                        // Park the ALU on a known zero operation while nothing is pending.
                        alu_s <= 3'b000;
                        alu_a <= '0;
                        alu_b <= '0;
                    end
                end
                EXEC: begin
                    rsp_acc   <= alu_acc;
                    rsp_flag  <= alu_flag;
                    rsp_mulh  <= (alu_s == 3'b111) ? alu_mulh : '0;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU stand-in, scoreboard fed at each handshake,
// and a negedge monitor checking arbitration order, timing and response contents.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_s;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
    logic [7:0]  alu_acc, alu_mulh, alu_flag;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0]  rsp_acc, rsp_mulh, rsp_flag;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_acc(alu_acc), .alu_mulh(alu_mulh), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_acc(rsp_acc), .rsp_mulh(rsp_mulh), .rsp_flag(rsp_flag),
        .busy(busy), .op_count(op_count)
    );

    // ALU stand-in; returns {flag, mulh, acc}. mulh is always the high product so gating shows.
    function automatic logic [23:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [8:0]  sum, dif;
        logic [7:0]  acc, flag;
        p   = a * b;
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        case (s)
            3'd0: acc = a;
            3'd1: acc = a & b;
            3'd2: acc = a | b;
            3'd3: acc = a ^ b;
            3'd4: acc = a >> 1;
            3'd5: acc = sum[7:0];
            3'd6: acc = dif[7:0];
            default: acc = p[7:0];
        endcase
        flag      = 8'h00;
        flag[3:0] = a[3:0] ^ b[3:0];
        flag[4]   = (s == 3'd5) && sum[8];
        flag[5]   = (s == 3'd6) && dif[8];
        flag[6]   = (acc == 8'h00);
        flag[7]   = acc[7];
        return {flag, p[15:8], acc};
    endfunction

    always_comb {alu_flag, alu_mulh, alu_acc} = alu_f(alu_s, alu_a, alu_b);

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hs_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done = 0;
    logic [15:0] m_cnt = 16'h0;
    logic        m_last = 1'b1;
    bit          seen = 0;
    bit          idle_prev = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: reference arbitration, scoreboard push on handshake, compare on response.
    always @(negedge clk) begin
        logic       h0, h1, eg;
        logic [23:0] r;
        exp_t       e;
        if (!rst_n) begin
            sb.delete();
            m_cnt     = 16'h0;
            m_last    = 1'b1;
            seen      = 0;
            idle_prev = 0;
        end else begin
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            if (busy) begin
                chk("ready_while_busy", {req1_ready, req0_ready}, 2'b00);
            end else begin
                if (req0_valid || req1_valid) begin
                    eg = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                    chk("grant", {req1_ready, req0_ready}, eg ? 2'b10 : 2'b01);
                    if (h0 || h1) begin
                        e.id     = h1;
                        e.op     = h1 ? req1_op : req0_op;
                        e.a      = h1 ? req1_a : req0_a;
                        e.b      = h1 ? req1_b : req0_b;
                        e.hs_cyc = cyc + 1;
                        sb.push_back(e);
                        m_last = h1;
                    end
                end else begin
                    chk("ready_no_req", {req1_ready, req0_ready}, 2'b00);
                end
                if (idle_prev)
                    chk("idle_drive", {alu_s, alu_a, alu_b}, 19'h0);
            end
            idle_prev = !busy && !h0 && !h1;
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 with no request outstanding (t=%0t)", $time);
                end else begin
                    e = sb[0];
                    r = alu_f(e.op, e.a, e.b);
                    if (!seen) begin
                        // Raised after handshake edge + 1, so sampled high at handshake edge + 2.
                        chk("latency", cyc, e.hs_cyc + 1);
                        chk("op_count", op_count, m_cnt);
                    end
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_acc", rsp_acc, r[7:0]);
                    chk("rsp_mulh", rsp_mulh, (e.op == 3'b111) ? r[15:8] : 8'h00);
                    chk("rsp_flag", rsp_flag, r[23:16]);
                    chk("alu_drive", {alu_s, alu_a, alu_b}, {e.op, e.a, e.b});
                    seen = 1;
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        m_cnt = m_cnt + 16'd1;
                        seen  = 0;
                    end
                end
            end
        end
    end

    task automatic start(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (!id) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
    endtask

    task automatic wait_hs(input bit id);
        int n = 0;
        bit got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        chk(id ? "hs1_timeout" : "hs0_timeout", got, 1'b1);
        @(posedge clk);
        #1;
        if (!id) req0_valid = 1'b0;
        else     req1_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        bit got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = rsp_valid;
        end
        chk("rsp_timeout", got, 1'b1);
    endtask

    task automatic reset_dut();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [59:0] snap;
        logic [15:0] cnt0;
        int          n;
        logic [1:0]  id_seq [4];
        logic [15:0] prod   [4];

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 8'h0; req0_b = 8'h0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 8'h0; req1_b = 8'h0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, rsp_valid, op_count}, 18'h0);
        chk("reset_drive", {alu_s, alu_a, alu_b}, 19'h0);
        chk("reset_rsp", {rsp_id, rsp_acc, rsp_mulh, rsp_flag}, 25'h0);
        chk("reset_ready", {req1_ready, req0_ready}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed: add with carry, subtract to zero, shift right.
        start(0, 3'b101, 8'hF0, 8'h20); wait_hs(0); wait_rsp();
        chk("add_acc", rsp_acc, 8'h10);
        chk("add_carry", rsp_flag[4], 1'b1);
        chk("add_id", rsp_id, 1'b0);
        chk("add_mulh", rsp_mulh, 8'h00);
        @(posedge clk); #1;
        start(0, 3'b110, 8'h05, 8'h05); wait_hs(0); wait_rsp();
        chk("sub_acc", rsp_acc, 8'h00);
        chk("sub_zero", rsp_flag[6], 1'b1);
        @(posedge clk); #1;
        start(1, 3'b100, 8'h81, 8'h00); wait_hs(1); wait_rsp();
        chk("shr_acc", rsp_acc, 8'h40);
        @(posedge clk); #1;

        // Contention from reset: both multiply continuously.
        reset_dut();
        req0_op = 3'b111; req0_a = 8'h10; req0_b = 8'h10;
        req1_op = 3'b111; req1_a = 8'hFF; req1_b = 8'h02;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp();
            id_seq[k] = {1'b0, rsp_id};
            prod[k]   = {rsp_mulh, rsp_acc};
            @(posedge clk); #1;
            if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        for (int k = 0; k < 4; k++) begin
            chk("rr_id", id_seq[k], (k % 2 == 0) ? 2'd0 : 2'd1);
            chk("rr_prod", prod[k], (k % 2 == 0) ? 16'h0100 : 16'h01FE);
        end

        // Back-pressure with req1 waiting.
        rsp_ready = 1'b0;
        start(0, 3'b011, 8'h5A, 8'h3C); wait_hs(0);
        start(1, 3'b010, 8'h11, 8'h22);
        wait_rsp();
        snap = {rsp_id, rsp_acc, rsp_mulh, rsp_flag, alu_a, alu_b, alu_s, op_count};
        cnt0 = op_count;
        repeat (10) begin
            @(negedge clk);
            chk("bp_stable", {rsp_id, rsp_acc, rsp_mulh, rsp_flag, alu_a, alu_b, alu_s, op_count}, snap);
            chk("bp_req1_ready", req1_ready, 1'b0);
            chk("bp_valid", rsp_valid, 1'b1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_hs(1);
        chk("bp_count", op_count, cnt0 + 16'd1);
        wait_rsp();
        chk("bp_granted", rsp_id, 1'b1);
        @(posedge clk); #1;

        // Reset while the operation is in EXEC.
        start(0, 3'b111, 8'h03, 8'h04); wait_hs(0);
        chk("exec_state", {busy, rsp_valid}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_exec_ctrl", {busy, rsp_valid, op_count}, 18'h0);
        chk("rst_exec_drive", {alu_s, alu_a, alu_b}, 19'h0);
        chk("rst_exec_rsp", {rsp_id, rsp_acc, rsp_mulh, rsp_flag}, 25'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_rsp_after_rst", rsp_valid, 1'b0);
        end

        // Randomised traffic on both requesters with random back-pressure.
        done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    start(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                    wait_hs(0);
                end
                done++;
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    start(1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
                    wait_hs(1);
                end
                done++;
            end
            begin
                while (done < 2) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("sb_drain", sb.size(), 0);

        // Counter wrap: preset near the top, then complete two operations.
        @(posedge clk); #1;
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        m_cnt = 16'hFFFE;
        start(1, 3'b001, 8'hC3, 8'h0F); wait_hs(1); wait_rsp();
        @(negedge clk);
        chk("count_ffff", op_count, 16'hFFFF);
        @(posedge clk); #1;
        start(0, 3'b000, 8'h77, 8'h00); wait_hs(0); wait_rsp();
        @(negedge clk);
        chk("count_wrap", op_count, 16'h0000);

        repeat (3) @(negedge clk);
        chk("sb_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
